fft_output_serializer: RTL and testbench

FFT_OUTPUT_SERIALIZER -- requirements
Module: fft_output_serializer

---
 rtl/fft_output_serializer.sv | 146 ++++++++++++++
 tb/tb_fft_output_serializer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fft_output_serializer.sv
// fft_output_serializer
//   Captures one 32-word FFT stage output frame and streams it out as one word
//   per beat. Words leave in 5-bit bit-reversed or natural index order. The
//   handshake is valid/ready. The next frame may load on the same edge that
//   transfers the last beat, so back-to-back frames have no bubble.
//
// Ports
//   CLK            rising-edge clock
//   RST            asynchronous active-low reset
//   i_c0..i_c31    parallel input words, captured on an accepted load
//   i_load         request to capture i_c0..i_c31
//   i_ready        downstream accepts the current beat
//   o_data         current serial word (buffer[o_index])
//   o_index        buffer index of the word on o_data
//   o_valid        o_data/o_index/o_last are valid
//   o_last         high on the 32nd beat of a frame
//   o_busy         high while a frame is being emitted
//   o_drop         one-cycle pulse after an i_load that was ignored
module fft_output_serializer #(
    parameter int unsigned p_dataBits   = 28,
    parameter int unsigned p_bitReverse = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [p_dataBits-1:0] i_c0,
    input  logic [p_dataBits-1:0] i_c1,
    input  logic [p_dataBits-1:0] i_c2,
    input  logic [p_dataBits-1:0] i_c3,
    input  logic [p_dataBits-1:0] i_c4,
    input  logic [p_dataBits-1:0] i_c5,
    input  logic [p_dataBits-1:0] i_c6,
    input  logic [p_dataBits-1:0] i_c7,
    input  logic [p_dataBits-1:0] i_c8,
    input  logic [p_dataBits-1:0] i_c9,
    input  logic [p_dataBits-1:0] i_c10,
    input  logic [p_dataBits-1:0] i_c11,
    input  logic [p_dataBits-1:0] i_c12,
    input  logic [p_dataBits-1:0] i_c13,
    input  logic [p_dataBits-1:0] i_c14,
    input  logic [p_dataBits-1:0] i_c15,
    input  logic [p_dataBits-1:0] i_c16,
    input  logic [p_dataBits-1:0] i_c17,
    input  logic [p_dataBits-1:0] i_c18,
    input  logic [p_dataBits-1:0] i_c19,
    input  logic [p_dataBits-1:0] i_c20,
    input  logic [p_dataBits-1:0] i_c21,
    input  logic [p_dataBits-1:0] i_c22,
    input  logic [p_dataBits-1:0] i_c23,
    input  logic [p_dataBits-1:0] i_c24,
    input  logic [p_dataBits-1:0] i_c25,
    input  logic [p_dataBits-1:0] i_c26,
    input  logic [p_dataBits-1:0] i_c27,
    input  logic [p_dataBits-1:0] i_c28,
    input  logic [p_dataBits-1:0] i_c29,
    input  logic [p_dataBits-1:0] i_c30,
    input  logic [p_dataBits-1:0] i_c31,
    input  logic                  i_load,
    input  logic                  i_ready,
    output logic [p_dataBits-1:0] o_data,
    output logic [4:0]            o_index,
    output logic                  o_valid,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_drop
);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t                state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic                  drop_q, drop_d;
    logic [p_dataBits-1:0] buf_q [32];
    logic [p_dataBits-1:0] buf_d [32];
    logic [p_dataBits-1:0] in_words [32];

    logic       send;
    logic       last;
    logic       xfer;
    logic       accept;
    logic [4:0] rd_idx;

    always_comb begin
        in_words[0]  = i_c0;   in_words[1]  = i_c1;   in_words[2]  = i_c2;   in_words[3]  = i_c3;
        in_words[4]  = i_c4;   in_words[5]  = i_c5;   in_words[6]  = i_c6;   in_words[7]  = i_c7;
        in_words[8]  = i_c8;   in_words[9]  = i_c9;   in_words[10] = i_c10;  in_words[11] = i_c11;
        in_words[12] = i_c12;  in_words[13] = i_c13;  in_words[14] = i_c14;  in_words[15] = i_c15;
        in_words[16] = i_c16;  in_words[17] = i_c17;  in_words[18] = i_c18;  in_words[19] = i_c19;
        in_words[20] = i_c20;  in_words[21] = i_c21;  in_words[22] = i_c22;  in_words[23] = i_c23;
        in_words[24] = i_c24;  in_words[25] = i_c25;  in_words[26] = i_c26;  in_words[27] = i_c27;
        in_words[28] = i_c28;  in_words[29] = i_c29;  in_words[30] = i_c30;  in_words[31] = i_c31;
    end

    // Outputs depend only on registered state, so the asynchronous reset
    // drops o_valid at once and the word holds steady under backpressure.
    always_comb begin
        send    = (state_q == ST_SEND);
        last    = send && (cnt_q == 5'd31);
        rd_idx  = (p_bitReverse != 0) ? {cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3], cnt_q[4]}
                                      : cnt_q;
        o_valid = send;
        o_busy  = send;
        o_last  = last;
        o_index = rd_idx;
        o_data  = buf_q[rd_idx];
        o_drop  = drop_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        xfer    = send && i_ready;
        accept  = i_load && (!send || (xfer && last));
        drop_d  = i_load && !accept;

        if (accept) begin
            buf_d   = in_words;
            cnt_d   = '0;
            state_d = ST_SEND;
        end else if (xfer) begin
            if (last) begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_fft_output_serializer.sv
module tb_fft_output_serializer;

    localparam int unsigned W = 28;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic [W-1:0] c [32];
    logic         i_load = 1'b0;
    logic         i_ready = 1'b0;

    logic [W-1:0] br_data, nt_data;
    logic [4:0]   br_index, nt_index;
    logic         br_valid, br_last, br_busy, br_drop;
    logic         nt_valid, nt_last, nt_busy, nt_drop;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    fft_output_serializer #(.p_dataBits(W), .p_bitReverse(1)) dut_br (
        .CLK(CLK), .RST(RST),
        .i_c0(c[0]),   .i_c1(c[1]),   .i_c2(c[2]),   .i_c3(c[3]),
        .i_c4(c[4]),   .i_c5(c[5]),   .i_c6(c[6]),   .i_c7(c[7]),
        .i_c8(c[8]),   .i_c9(c[9]),   .i_c10(c[10]), .i_c11(c[11]),
        .i_c12(c[12]), .i_c13(c[13]), .i_c14(c[14]), .i_c15(c[15]),
        .i_c16(c[16]), .i_c17(c[17]), .i_c18(c[18]), .i_c19(c[19]),
        .i_c20(c[20]), .i_c21(c[21]), .i_c22(c[22]), .i_c23(c[23]),
        .i_c24(c[24]), .i_c25(c[25]), .i_c26(c[26]), .i_c27(c[27]),
        .i_c28(c[28]), .i_c29(c[29]), .i_c30(c[30]), .i_c31(c[31]),
        .i_load(i_load), .i_ready(i_ready),
        .o_data(br_data), .o_index(br_index), .o_valid(br_valid),
        .o_last(br_last), .o_busy(br_busy), .o_drop(br_drop)
    );

    fft_output_serializer #(.p_dataBits(W), .p_bitReverse(0)) dut_nt (
        .CLK(CLK), .RST(RST),
        .i_c0(c[0]),   .i_c1(c[1]),   .i_c2(c[2]),   .i_c3(c[3]),
        .i_c4(c[4]),   .i_c5(c[5]),   .i_c6(c[6]),   .i_c7(c[7]),
        .i_c8(c[8]),   .i_c9(c[9]),   .i_c10(c[10]), .i_c11(c[11]),
        .i_c12(c[12]), .i_c13(c[13]), .i_c14(c[14]), .i_c15(c[15]),
        .i_c16(c[16]), .i_c17(c[17]), .i_c18(c[18]), .i_c19(c[19]),
        .i_c20(c[20]), .i_c21(c[21]), .i_c22(c[22]), .i_c23(c[23]),
        .i_c24(c[24]), .i_c25(c[25]), .i_c26(c[26]), .i_c27(c[27]),
        .i_c28(c[28]), .i_c29(c[29]), .i_c30(c[30]), .i_c31(c[31]),
        .i_load(i_load), .i_ready(i_ready),
        .o_data(nt_data), .o_index(nt_index), .o_valid(nt_valid),
        .o_last(nt_last), .o_busy(nt_busy), .o_drop(nt_drop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] rev5(input logic [4:0] v);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = v[4-i];
        return r;
    endfunction

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic fill(input int base);
        for (int k = 0; k < 32; k++) c[k] = W'(k + base);
    endtask

    initial begin
        int exp_b;
        int cyc;
        logic [4:0] ri;

        // Reset held for 3 cycles, then idle with i_ready high.
        fill(100);
        #1;
        repeat (3) tick();
        check("rst_valid", {31'b0, br_valid}, 0);
        check("rst_data",  {4'b0, br_data}, 0);
        check("rst_index", {27'b0, br_index}, 0);
        check("rst_flags", {28'b0, br_last, br_busy, br_drop, nt_valid}, 0);
        RST = 1'b1;
        i_ready = 1'b1;
        repeat (3) tick();
        check("idle_valid", {31'b0, br_valid}, 0);
        check("idle_data",  {4'b0, br_data}, 0);

        // One full frame: bit-reversed and natural instances side by side.
        i_load = 1'b1;
        tick();
        i_load = 1'b0;
        for (int b = 0; b < 32; b++) begin
            ri = rev5(5'(b));
            check("br_valid", {31'b0, br_valid}, 1);
            check("br_index", {27'b0, br_index}, {27'b0, ri});
            check("br_data",  {4'b0, br_data}, 32'(ri) + 100);
            check("br_last",  {31'b0, br_last}, (b == 31) ? 1 : 0);
            check("nt_index", {27'b0, nt_index}, b);
            check("nt_data",  {4'b0, nt_data}, b + 100);
            check("nt_last",  {31'b0, nt_last}, (b == 31) ? 1 : 0);
            tick();
        end
        check("end_valid",  {30'b0, br_valid, nt_valid}, 0);
        check("end_busy",   {30'b0, br_busy, nt_busy}, 0);
        check("idle_word0", {4'b0, br_data}, 100);

        // Backpressure: pseudo-random i_ready, every beat once and in order.
        fill(1000);
        for (int k = 0; k < 32; k++) c[k] = W'(k * 37 + 1000);
        i_load = 1'b1;
        tick();
        i_load = 1'b0;
        for (int k = 0; k < 32; k++) c[k] = '0;
        exp_b = 0;
        cyc = 0;
        while (exp_b < 32 && cyc < 400) begin
            ri = rev5(5'(exp_b));
            check("bp_valid", {31'b0, br_valid}, 1);
            check("bp_index", {27'b0, br_index}, {27'b0, ri});
            check("bp_data",  {4'b0, br_data}, 32'(ri) * 37 + 1000);
            check("bp_last",  {31'b0, br_last}, (exp_b == 31) ? 1 : 0);
            i_ready = 1'($urandom_range(0, 1));
            tick();
            if (i_ready) exp_b++;
            cyc++;
        end
        if (exp_b < 32) check("bp_timeout", 0, 1);
        check("bp_done", {31'b0, br_valid}, 0);

        // Drop during beat 10, back-to-back reload on the last beat.
        i_ready = 1'b1;
        fill(100);
        i_load = 1'b1;
        tick();
        i_load = 1'b0;
        for (int b = 0; b < 32; b++) begin
            ri = rev5(5'(b));
            check("b2b_data", {4'b0, br_data}, 32'(ri) + 100);
            check("b2b_drop", {31'b0, br_drop}, (b == 11) ? 1 : 0);
            i_load = 1'b0;
            if (b == 10) begin
                fill(500);
                i_load = 1'b1;
            end
            if (b == 31) begin
                fill(200);
                i_load = 1'b1;
            end
            tick();
        end
        i_load = 1'b0;
        check("b2b_valid", {31'b0, br_valid}, 1);
        check("b2b_index", {27'b0, br_index}, 0);
        check("b2b_data0", {4'b0, br_data}, 200);
        check("b2b_drop0", {31'b0, br_drop}, 0);

        // Mid-frame reset at beat 7 of the second frame.
        repeat (7) tick();
        check("mid_index", {27'b0, br_index}, {27'b0, rev5(5'd7)});
        RST = 1'b0;
        #1;
        check("mid_async_valid", {31'b0, br_valid}, 0);
        check("mid_async_data",  {4'b0, br_data}, 0);
        tick();
        RST = 1'b1;
        repeat (4) tick();
        check("mid_idle_valid", {30'b0, br_valid, br_busy}, 0);

        // Load coincident with the first edge after reset release.
        RST = 1'b0;
        fill(300);
        i_load = 1'b1;
        tick();
        RST = 1'b1;
        tick();
        i_load = 1'b0;
        check("rel_valid", {31'b0, br_valid}, 1);
        check("rel_data",  {4'b0, br_data}, 300);
        check("rel_nt1",   {4'b0, nt_data}, 300);
        tick();
        check("rel_beat1", {4'b0, br_data}, 316);
        repeat (31) tick();
        check("rel_done",  {31'b0, br_valid}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
